// File: rtl/mac_vec_p_if.sv
// Bus bundle for mac_vec_p: job control, input beat handshake and result
// handshake. The master side (job issuer/consumer) drives start/bias/len/shift,
// beats and out_ready. The slave side (the MAC) returns in_ready, out_valid,
// y, sat_flag and busy.
interface mac_vec_p_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int OUT_W  = 16,
  parameter int LEN_W  = 8
);
  logic                      start;
  logic [DATA_W-1:0]         bias_in;
  logic [LEN_W-1:0]          len;
  logic [3:0]                shift;
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   a_vec;
  logic [LANES*DATA_W-1:0]   b_vec;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   y;
  logic                      sat_flag;
  logic                      busy;

  modport master (
    output start, bias_in, len, shift, in_valid, a_vec, b_vec, out_ready,
    input  in_ready, out_valid, y, sat_flag, busy
  );

  modport slave (
    input  start, bias_in, len, shift, in_valid, a_vec, b_vec, out_ready,
    output in_ready, out_valid, y, sat_flag, busy
  );
endinterface

// File: rtl/mac_vec_p.sv
// mac_vec_p: vector dot-product MAC. A job is started with a bias, a beat
// count and an output shift; each accepted beat adds the full-precision sum of
// LANES signed products into a saturating accumulator. After the last beat the
// accumulator is arithmetically shifted, clamped to OUT_W and held on y until
// the consumer takes it.
// Ports:
//   clkext  - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   en_mac  - clock enable; low freezes all state and blocks both handshakes
//   bus     - mac_vec_p_if.slave (job control, beat and result handshakes)

// Single lane signed multiplier.
module mac_vec_p_lane #(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] p
);
  assign p = a * b;
endmodule

module mac_vec_p #(
  parameter int DATA_W      = 8,
  parameter int LANES       = 4,
  parameter int ACC_W       = 24,
  parameter int OUT_W       = 16,
  parameter int LEN_W       = 8,
  parameter bit BIAS_SIGNED = 1'b0
) (
  input logic        clkext,
  input logic        rst_n,
  input logic        en_mac,
  mac_vec_p_if.slave bus
);
  localparam int SUM_W = 2*DATA_W + $clog2(LANES);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]         count;
  logic [3:0]               shift_q;
  logic signed [OUT_W-1:0]  y_q;
  logic                     sat_q;

  // ---- lane products ----
  logic [LANES-1:0][2*DATA_W-1:0] prod;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_vec_p_lane #(.DATA_W(DATA_W)) u_lane (
      .a (bus.a_vec[i*DATA_W +: DATA_W]),
      .b (bus.b_vec[i*DATA_W +: DATA_W]),
      .p (prod[i])
    );
  end

  // Adder tree width grows by clog2(LANES) so the beat sum never overflows.
  logic signed [SUM_W-1:0] sum;
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++)
      sum = sum + SUM_W'($signed(prod[i]));
  end

  // ---- saturating accumulate, one guard bit ----
  logic signed [ACC_W:0]   acc_wide;
  logic                    acc_ovf;
  logic signed [ACC_W-1:0] acc_sat;

  assign acc_wide = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(sum);
  assign acc_ovf  = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
  assign acc_sat  = !acc_ovf ? acc_wide[ACC_W-1:0]
                             : (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX);

  logic signed [ACC_W-1:0] bias_ext;
  assign bias_ext = {{(ACC_W-DATA_W){BIAS_SIGNED & bus.bias_in[DATA_W-1]}}, bus.bias_in};

  // ---- output shift/clamp ----
  // In IDLE the source is the bias (LEN=0 job finishing straight from START);
  // otherwise it is the post-beat accumulator so y lands one cycle after the
  // final accept.
  logic signed [ACC_W-1:0] y_src, shifted;
  logic [3:0]              y_shamt;
  logic [ACC_W-OUT_W:0]    y_top;
  logic                    y_ovf;
  logic signed [OUT_W-1:0] y_sat;

  assign y_src   = (state_q == IDLE) ? bias_ext : acc_sat;
  assign y_shamt = (state_q == IDLE) ? bus.shift : shift_q;
  assign shifted = y_src >>> y_shamt;
  assign y_top   = shifted[ACC_W-1:OUT_W-1];
  assign y_ovf   = !((&y_top) | ~(|y_top));
  assign y_sat   = !y_ovf ? shifted[OUT_W-1:0]
                          : (shifted[ACC_W-1] ? OUT_MIN : OUT_MAX);

  // ---- control ----
  logic accept, load, last;
  assign accept = en_mac & bus.in_valid & (state_q == ACCUM);
  assign load   = en_mac & bus.start & (state_q == IDLE);
  assign last   = (count == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && last) state_d = DONE;
      DONE:    if (en_mac && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkext or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clkext or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      count   <= '0;
      shift_q <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
    end else if (load) begin
      acc     <= bias_ext;
      count   <= bus.len;
      shift_q <= bus.shift;
      sat_q   <= 1'b0;
      if (bus.len == '0) begin
        y_q   <= y_sat;
        sat_q <= y_ovf;
      end
    end else if (accept) begin
      acc   <= acc_sat;
      count <= count - LEN_W'(1);
      if (last) y_q <= y_sat;
      // Sticky: once set it stays until the next job loads.
      if (acc_ovf || (last && y_ovf)) sat_q <= 1'b1;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM) & en_mac;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.y         = y_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_mac_vec_p.sv
// Directed testbench for mac_vec_p. Two DUTs share the same stimulus: one with
// zero-extended bias, one with sign-extended bias. Each job pushes its
// hand-computed result into a scoreboard; a monitor pops on every output
// handshake and checks held outputs for stability while not consumed.
module tb_mac_vec_p;
  typedef struct {
    int y0; int s0; int y1; int s1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en_mac;
  always #5 clk = ~clk;

  mac_vec_p_if #(.DATA_W(8), .LANES(4), .OUT_W(16), .LEN_W(8)) bus0 ();
  mac_vec_p_if #(.DATA_W(8), .LANES(4), .OUT_W(16), .LEN_W(8)) bus1 ();

  assign bus1.start     = bus0.start;
  assign bus1.bias_in   = bus0.bias_in;
  assign bus1.len       = bus0.len;
  assign bus1.shift     = bus0.shift;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a_vec     = bus0.a_vec;
  assign bus1.b_vec     = bus0.b_vec;
  assign bus1.out_ready = bus0.out_ready;

  mac_vec_p #(.BIAS_SIGNED(1'b0)) dut0 (.clkext(clk), .rst_n(rst_n), .en_mac(en_mac), .bus(bus0));
  mac_vec_p #(.BIAS_SIGNED(1'b1)) dut1 (.clkext(clk), .rst_n(rst_n), .en_mac(en_mac), .bus(bus1));

  int tests = 0;
  int fails = 0;
  exp_t q[$];
  logic [31:0] beat_a[$];
  logic [31:0] beat_b[$];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  // Monitor: sampled mid-low-phase, after stimulus for the coming edge settles.
  initial begin
    bit held = 0;
    int hold_y = 0, hold_s = 0;
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && bus0.out_valid) begin
        check("valid_pair", int'(bus1.out_valid), 1);
        if (held) begin
          check("y_hold", int'(bus0.y), hold_y);
          check("sat_hold", int'(bus0.sat_flag), hold_s);
        end
        if (bus0.out_ready && en_mac) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: got y=%0d expected none", bus0.y);
          end else begin
            e = q.pop_front();
            check("y0", int'(bus0.y), e.y0);
            check("sat0", int'(bus0.sat_flag), e.s0);
            check("y1", int'(bus1.y), e.y1);
            check("sat1", int'(bus1.sat_flag), e.s1);
          end
          held = 0;
        end else begin
          held = 1; hold_y = int'(bus0.y); hold_s = int'(bus0.sat_flag);
        end
      end else held = 0;
    end
  end

  // One job. gaps: stall/enable/start-noise patterns during beats.
  // hold: cycles to keep out_ready low in DONE. abort_at: reset after that
  // many accepted beats. no_wait: start in the current low phase.
  task automatic run_job(input int bias, input int len, input int shift,
                         input int hold, input bit gaps, input int abort_at,
                         input bit no_wait, input exp_t e);
    int sent = 0, cyc = 0;
    q.push_back(e);
    if (!no_wait) @(negedge clk);
    en_mac = 1; bus0.start = 1; bus0.bias_in = bias[7:0];
    bus0.len = len[7:0]; bus0.shift = shift[3:0];
    bus0.out_ready = (hold == 0); bus0.in_valid = 0;
    while (sent < len && cyc < 4000) begin
      @(negedge clk);
      bus0.start    = gaps && (cyc % 5 == 3);
      en_mac        = !(gaps && (cyc % 4 == 2));
      bus0.in_valid = !(gaps && (cyc % 3 == 1));
      bus0.a_vec    = beat_a[sent % beat_a.size()];
      bus0.b_vec    = beat_b[sent % beat_b.size()];
      #1;
      if (bus0.in_valid && bus0.in_ready) sent++;
      if (abort_at > 0 && sent == abort_at) begin
        rst_n = 0; #1;
        check("rst_y", int'(bus0.y), 0);
        check("rst_valid", int'(bus0.out_valid), 0);
        check("rst_ready", int'(bus0.in_ready), 0);
        check("rst_busy", int'(bus0.busy), 0);
        check("rst_sat", int'(bus0.sat_flag), 0);
        q.delete(); bus0.in_valid = 0;
        #1 rst_n = 1;
        return;
      end
      cyc++;
    end
    if (cyc >= 4000) check("beat_timeout", sent, len);
    @(negedge clk);
    bus0.start = 0; bus0.in_valid = 0; en_mac = 1; #1;
    check("latency_valid", int'(bus0.out_valid), 1);
    check("in_ready_done", int'(bus0.in_ready), 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      bus0.start = (k == 1);        // must be ignored in DONE
      en_mac = (k != 3);
      bus0.out_ready = (k == 3);    // ready but frozen by en_mac
    end
    if (hold > 0) begin
      @(negedge clk);
      bus0.start = 0; en_mac = 1; bus0.out_ready = 1;
    end
    cyc = 0;
    do begin
      @(negedge clk); #1; cyc++;
    end while (bus0.busy && cyc < 20);
    check("job_idle", int'(bus0.busy), 0);
  endtask

  initial begin
    rst_n = 0; en_mac = 1;
    bus0.start = 0; bus0.bias_in = 0; bus0.len = 0; bus0.shift = 0;
    bus0.in_valid = 0; bus0.a_vec = 0; bus0.b_vec = 0; bus0.out_ready = 1;
    #12;
    check("init_y", int'(bus0.y), 0);
    check("init_valid", int'(bus0.out_valid), 0);
    check("init_ready", int'(bus0.in_ready), 0);
    check("init_busy", int'(bus0.busy), 0);
    check("init_sat", int'(bus0.sat_flag), 0);
    @(negedge clk); rst_n = 1;

    // basic: 5 + (1+2+3+4) = 15
    beat_a = '{pk(1,2,3,4)}; beat_b = '{pk(1,1,1,1)};
    run_job(5, 1, 0, 0, 0, 0, 0, '{15, 0, 15, 0});

    // 2 beats of 4*16384: 131072 -> clamp 32767; >>>3 -> 16384
    beat_a = '{pk(-128,-128,-128,-128)}; beat_b = '{pk(-128,-128,-128,-128)};
    run_job(0, 2, 0, 0, 0, 0, 0, '{32767, 1, 32767, 1});
    run_job(0, 2, 3, 0, 0, 0, 0, '{16384, 0, 16384, 0});

    // 128 beats: acc clamps at 8388607, >>>15 -> 255
    run_job(0, 128, 15, 0, 0, 0, 0, '{255, 1, 255, 1});

    // saturated acc keeps accumulating: 8388607 - 65024 = 8323583, >>>15 -> 254
    beat_a.delete(); beat_b.delete();
    for (int i = 0; i < 128; i++) begin
      beat_a.push_back(pk(-128,-128,-128,-128)); beat_b.push_back(pk(-128,-128,-128,-128));
    end
    beat_a.push_back(pk(-128,-128,-128,-128)); beat_b.push_back(pk(127,127,127,127));
    run_job(0, 129, 15, 0, 0, 0, 0, '{254, 1, 254, 1});

    // LEN=0: bias straight out; 200 vs sign-extended -56
    run_job(200, 0, 0, 0, 0, 0, 0, '{200, 0, -56, 0});

    // floor shift: -3 >>> 1 = -2
    beat_a = '{pk(-1,0,0,0)}; beat_b = '{pk(3,0,0,0)};
    run_job(0, 1, 1, 0, 0, 0, 0, '{-2, 0, -2, 0});

    // negative clamp: 4 * (-128*127) = -65024 -> -32768
    beat_a = '{pk(-128,-128,-128,-128)}; beat_b = '{pk(127,127,127,127)};
    run_job(0, 1, 0, 0, 0, 0, 0, '{-32768, 1, -32768, 1});

    // stalls, enable drops, stray start, held output: 3 + 10 + 26 - 20 = 19
    beat_a = '{pk(1,2,3,4), pk(1,1,1,1), pk(-1,-2,-3,-4)};
    beat_b = '{pk(1,1,1,1), pk(5,6,7,8), pk(2,2,2,2)};
    run_job(3, 3, 0, 5, 1, 0, 0, '{19, 0, 19, 0});

    // reset after 3 of 8 beats, then a fresh job on the first edge
    beat_a = '{pk(1,2,3,4)}; beat_b = '{pk(1,1,1,1)};
    run_job(5, 8, 0, 0, 0, 3, 0, '{0, 0, 0, 0});
    run_job(5, 1, 0, 0, 0, 0, 1, '{15, 0, 15, 0});

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mac_vec_p.md
MAC_VEC_P -- requirements
Module: mac_vec_p

Interface
REQ-001 Parameter DATA_W, default 8, lane operand width (signed two's complement).
REQ-002 Parameter LANES, default 4, number of parallel multiplier lanes (>=1).
REQ-003 Parameter ACC_W, default 24, accumulator width (>= 2*DATA_W + clog2(LANES)).
REQ-004 Parameter OUT_W, default 16, result width (<= ACC_W).
REQ-005 Parameter LEN_W, default 8, beat-count width.
REQ-006 Parameter BIAS_SIGNED, default 0: 0 zero-extends BIAS_IN, 1 sign-extends it.
REQ-007 CLKEXT  in  1  single clock, all state on rising edge.
REQ-008 RST_N  in  1  reset, asynchronous, active-low.
REQ-009 EN_MAC  in  1  clock enable; 0 freezes all state and blocks every handshake.
REQ-010 START  in  1  begin a dot-product job (sampled in IDLE only).
REQ-011 BIAS_IN  in  DATA_W  accumulator initial value, extended per BIAS_SIGNED.
REQ-012 LEN  in  LEN_W  number of input beats for the job, sampled with START.
REQ-013 SHIFT  in  4  output arithmetic right-shift amount, sampled with START.
REQ-014 IN_VALID  in  1  A_VEC/B_VEC beat valid.
REQ-015 IN_READY  out  1  beat accept; = (state==ACCUM) & EN_MAC.
REQ-016 A_VEC, B_VEC  in  LANES*DATA_W each  packed signed operands, lane i at bits [i*DATA_W +: DATA_W].
REQ-017 OUT_VALID  out  1  result valid; = (state==DONE).
REQ-018 OUT_READY  in  1  result consumer ready.
REQ-019 Y  out  OUT_W  signed result, registered.
REQ-020 SAT_FLAG  out  1  sticky: any saturation during the current job.
REQ-021 BUSY  out  1  = (state != IDLE).

Function
REQ-022 FSM states IDLE, ACCUM, DONE.
REQ-023 IDLE: START&EN_MAC loads acc=extended BIAS_IN, count=LEN, latches SHIFT, clears SAT_FLAG; next ACCUM if LEN!=0, else DONE.
REQ-024 Beat accepted when IN_VALID&IN_READY; sum = full-precision sum of LANES products A[i]*B[i] (2*DATA_W+clog2(LANES) bits, no loss).
REQ-025 On accept acc <= saturate_ACC_W(acc + sum), computed at ACC_W+1 bits; overflow clamps to 2^(ACC_W-1)-1 / -2^(ACC_W-1) and sets SAT_FLAG.
REQ-026 On accept count decrements; accept with count==1 moves to DONE and writes Y.
REQ-027 Y = saturate_OUT_W(final acc >>> SHIFT), arithmetic shift (floor); clamp sets SAT_FLAG.
REQ-028 Latency: Y and OUT_VALID valid the cycle after the final accepted beat (LEN=0: the cycle after START).
REQ-029 IN_VALID gaps insert stall cycles; acc and count unchanged.
REQ-030 DONE: Y, SAT_FLAG stable until OUT_READY&EN_MAC, then IDLE; SAT_FLAG held until next START.
REQ-031 START outside IDLE ignored; START and handshake in the same cycle cannot conflict (disjoint states).
REQ-032 Saturated acc continues accumulating (may return toward range); SAT_FLAG stays set.
REQ-033 LEN=2^LEN_W-1 is the maximum job; count never wraps.

Reset
REQ-034 RST_N low, at any time including mid-job: state=IDLE, acc=0, count=0, Y=0, SAT_FLAG=0, OUT_VALID=0, IN_READY=0, BUSY=0, immediately without clock.
REQ-035 First START is honoured on the first rising edge after RST_N deasserts.

Verification (defaults)
REQ-036 BIAS_IN=5, LEN=1, SHIFT=0, A=[1,2,3,4], B=[1,1,1,1] -> Y=15 one cycle after accept, SAT_FLAG=0.
REQ-037 LEN=2, all A=B=-128: SHIFT=0 -> Y=32767, SAT_FLAG=1; SHIFT=3 -> Y=16384, SAT_FLAG=0.
REQ-038 BIAS_IN=0, LEN=128, all A=B=-128, SHIFT=15 -> acc clamps at 8388607, Y=255, SAT_FLAG=1.
REQ-039 LEN=0, BIAS_IN=200 (BIAS_SIGNED=0) -> IN_READY never 1, Y=200; BIAS_SIGNED=1 -> Y=-56.
REQ-040 Hold OUT_READY=0 5 cycles, pulse START, toggle EN_MAC=0 and IN_VALID gaps -> Y/OUT_VALID stable, START ignored, no beat lost or duplicated.
REQ-041 RST_N low mid-ACCUM after 3 of 8 beats -> all outputs 0 asynchronously; new job after release gives correct result.
